// File: rtl/contador_horas.sv
// Hour stage of a digital clock: counts 0-23 on minute carries or manual
// set pulses, formats the hour as BCD in 24 h or 12 h mode, and emits a
// one-clock day carry when a minute carry rolls the hour over midnight.
module contador_horas #(
  parameter int HORA_INICIAL = 0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       modifHor,
  input  logic       ajusteHor,
  input  logic       modo12,
  output logic [1:0] decenas,
  output logic [3:0] unidades,
  output logic       pm,
  output logic       finDia
);

  localparam logic [4:0] HORA_RST = 5'(HORA_INICIAL);

  logic [4:0] hora;
  logic [4:0] hora_next;
  logic       aj_sync_p0;
  logic       aj_sync_p1;
  logic       aj_prev_p2;
  logic       fill_p0;
  logic       fill_p1;
  logic       aj_armed;
  logic       ajPulse;

  // Map a binary hour to {tens, units} BCD for the selected display mode.
  function automatic logic [5:0] hora_a_bcd(input logic [4:0] h, input logic m12);
    logic [4:0] v;
    v = h;
    if (m12) begin
      if (h == 5'd0) v = 5'd12;
      else if (h > 5'd12) v = h - 5'd12;
    end
    if (v >= 5'd20) return {2'd2, 4'(v - 5'd20)};
    else if (v >= 5'd10) return {2'd1, 4'(v - 5'd10)};
    else return {2'd0, v[3:0]};
  endfunction

  // Synchronize the pushbutton, keep the previous synchronized level for
  // edge detection, and arm the detector only once the synchronized button
  // has been seen released after reset (a button held through reset must
  // be released before it can count).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      aj_sync_p0 <= 1'b0;
      aj_sync_p1 <= 1'b0;
      aj_prev_p2 <= 1'b0;
      fill_p0    <= 1'b0;
      fill_p1    <= 1'b0;
      aj_armed   <= 1'b0;
    end else begin
      aj_sync_p0 <= ajusteHor;
      aj_sync_p1 <= aj_sync_p0;
      aj_prev_p2 <= aj_sync_p1;
      fill_p0    <= 1'b1;
      fill_p1    <= fill_p0;
      if (fill_p1 && !aj_sync_p1) aj_armed <= 1'b1;
    end
  end

  assign ajPulse = aj_sync_p1 & ~aj_prev_p2 & aj_armed;

  // Next hour: a carry and a set pulse in the same cycle still add one.
  always_comb begin
    hora_next = hora;
    if (modifHor || ajPulse) begin
      hora_next = (hora == 5'd23) ? 5'd0 : hora + 5'd1;
    end
  end

  // Hour register, display registers fed from the next hour so the display
  // tracks the hour on the same edge, and the midnight carry pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hora     <= HORA_RST;
      decenas  <= 2'd0;
      unidades <= 4'd0;
      pm       <= 1'b0;
      finDia   <= 1'b0;
    end else begin
      hora                <= hora_next;
      {decenas, unidades} <= hora_a_bcd(hora_next, modo12);
      pm                  <= (hora_next >= 5'd12);
      finDia              <= modifHor && (hora == 5'd23);
    end
  end

endmodule

// File: tb/tb_contador_horas.sv
// Directed bench for contador_horas: a behavioural hour model is advanced
// every clock and compared against the outputs, and hand-computed literal
// expectations pin the key points of the sequence.
module tb_contador_horas;

  localparam int HI = 0;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       modifHor = 1'b0;
  logic       ajusteHor = 1'b0;
  logic       modo12 = 1'b0;
  logic [1:0] decenas;
  logic [3:0] unidades;
  logic       pm;
  logic       finDia;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int hm = HI;
  int e_dec = 0;
  int e_uni = 0;
  bit e_pm = 1'b0;
  bit e_fin = 1'b0;
  bit hist[$];

  contador_horas #(.HORA_INICIAL(HI)) dut (
    .clock(clk),
    .reset_n(reset_n),
    .modifHor(modifHor),
    .ajusteHor(ajusteHor),
    .modo12(modo12),
    .decenas(decenas),
    .unidades(unidades),
    .pm(pm),
    .finDia(finDia)
  );

  always #5 clk = ~clk;

  function automatic void expect_disp(input int h, input bit m12, output int d, output int u);
    int v;
    if (m12) v = (h % 12 == 0) ? 12 : h % 12;
    else v = h;
    d = v / 10;
    u = v % 10;
  endfunction

  task automatic compare(input string nm, input int d, input int u, input int p, input int f);
    checks++;
    if (decenas !== 2'(d) || unidades !== 4'(u) || pm !== 1'(p) || finDia !== 1'(f)) begin
      errors++;
      $display("FAIL %s at %0t: got %0d%0d pm=%0d fin=%0d, expected %0d%0d pm=%0d fin=%0d",
               nm, $time, decenas, unidades, pm, finDia, d, u, p, f);
    end
  endtask

  task automatic lit(input string nm, input int d, input int u, input int p, input int f);
    compare(nm, d, u, p, f);
  endtask

  // One clock: drive inputs on the falling edge, advance the model on the
  // rising edge from the hour rules, then compare just after the edge.
  task automatic cyc(input logic r, input logic m, input logic a);
    bit pulse;
    bit dia;
    int n;
    @(negedge clk);
    reset_n   = r;
    modifHor  = m;
    ajusteHor = a;
    @(posedge clk);
    if (!reset_n) begin
      hm = HI;
      hist.delete();
      e_dec = 0; e_uni = 0; e_pm = 1'b0; e_fin = 1'b0;
    end else begin
      hist.push_back(a);
      n = hist.size();
      // a press first sampled two edges ago, after a released sample, counts now
      pulse = (n >= 4) && hist[n-3] && !hist[n-4];
      dia = m && (hm == 23);
      if (m || pulse) hm = (hm + 1) % 24;
      expect_disp(hm, modo12, e_dec, e_uni);
      e_pm  = (hm >= 12);
      e_fin = dia;
    end
    #1;
    compare("cycle", e_dec, e_uni, int'(e_pm), int'(e_fin));
  endtask

  task automatic pulses(input int k);
    for (int i = 0; i < k; i++) begin
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
    end
  endtask

  int t12[24] = '{12, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11,
                  12, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};

  initial begin
    #1 reset_n = 1'b0;
    #1 lit("reset_async", 0, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    lit("first_edge", 0, 0, 0, 0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0);

    // 24 h count to 23, then midnight rollover
    pulses(23);
    lit("h23", 2, 3, 1, 0);
    cyc(1'b1, 1'b1, 1'b0);
    lit("midnight", 0, 0, 0, 1);
    cyc(1'b1, 1'b0, 1'b0);
    lit("findia_once", 0, 0, 0, 0);

    // 12 h mode change and full sweep
    modo12 = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    lit("mode12_h0", 1, 2, 0, 0);
    for (int i = 1; i <= 24; i++) begin
      pulses(1);
      lit("sweep12", t12[i % 24] / 10, t12[i % 24] % 10, ((i % 24) >= 12) ? 1 : 0, 0);
    end
    modo12 = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    lit("mode24_back", 0, 0, 0, 0);

    // long press from hour 5 counts once, on the third edge
    pulses(5);
    lit("h5", 0, 5, 0, 0);
    cyc(1'b1, 1'b0, 1'b1);
    lit("aj_edge1", 0, 5, 0, 0);
    cyc(1'b1, 1'b0, 1'b1);
    lit("aj_edge2", 0, 5, 0, 0);
    cyc(1'b1, 1'b0, 1'b1);
    lit("aj_edge3", 0, 6, 0, 0);
    repeat (7) cyc(1'b1, 1'b0, 1'b1);
    lit("aj_hold", 0, 6, 0, 0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0);

    // manual wrap at 23 gives no day carry
    pulses(17);
    lit("h23_again", 2, 3, 1, 0);
    repeat (3) cyc(1'b1, 1'b0, 1'b1);
    lit("aj_wrap", 0, 0, 0, 0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    lit("aj_wrap_hold", 0, 0, 0, 0);

    // carry coincident with the set pulse at hour 7
    pulses(7);
    lit("h7", 0, 7, 0, 0);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    lit("coincident", 0, 8, 0, 0);
    cyc(1'b1, 1'b0, 1'b1);
    lit("coincident_hold", 0, 8, 0, 0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0);

    // asynchronous reset between edges at hour 15
    pulses(7);
    lit("h15", 1, 5, 1, 0);
    #2 reset_n = 1'b0;
    #1 lit("reset_mid", 0, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b0);
    modo12 = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    lit("reset_12h", 1, 2, 0, 0);
    repeat (2) cyc(1'b1, 1'b0, 1'b0);

    // reset during a press, button still held at release
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    repeat (6) cyc(1'b1, 1'b0, 1'b1);
    lit("held_release", 1, 2, 0, 0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    repeat (4) cyc(1'b1, 1'b0, 1'b1);
    lit("repress", 0, 1, 0, 0);
    repeat (2) cyc(1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/contador_horas.md
CONTADOR_HORAS -- requirements
Module: contador_horas

Interface
REQ-001 The block SHALL have one parameter: HORA_INICIAL, default 0, the hour (0-23) loaded by reset.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock, 1 Hz tick domain, rising-edge active.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port modifHor, input, 1 bit: carry pulse from the minute stage, asserted for exactly one clock in the cycle the minute stage wraps from 59 to 00.
REQ-005 The block SHALL have port ajusteHor, input, 1 bit: asynchronous manual-set pushbutton, active-high.
REQ-006 The block SHALL have port modo12, input, 1 bit: display mode, 0 = 24 h and 1 = 12 h.
REQ-007 The block SHALL have port decenas, output, 2 bits: BCD tens digit of the displayed hour.
REQ-008 The block SHALL have port unidades, output, 4 bits: BCD units digit of the displayed hour.
REQ-009 The block SHALL have port pm, output, 1 bit: 1 when the internal hour is 12-23, in both modes.
REQ-010 The block SHALL have port finDia, output, 1 bit: one-clock day-carry pulse for a downstream calendar stage.

Function
REQ-011 The internal hour SHALL be a 5-bit binary register, hora, with range 0-23.
REQ-012 ajusteHor SHALL pass through a two-flop synchronizer; a rising-edge detector on the synchronized signal SHALL produce the pulse ajPulse, and the detector flop SHALL be a third flop.
REQ-013 The path from an ajusteHor rising edge to ajPulse SHALL take 3 clock edges, and one press SHALL yield exactly one ajPulse regardless of hold time.
REQ-014 On a clock edge where modifHor=1 or ajPulse=1, hora SHALL advance by 1, and hora=23 SHALL wrap to 0.
REQ-015 When modifHor and ajPulse are both 1 in the same cycle, hora SHALL advance by exactly 1.
REQ-016 finDia SHALL be 1 for exactly the cycle following an edge where modifHor=1 and hora went from 23 to 0.
REQ-017 A wrap caused only by ajPulse SHALL NOT assert finDia.
REQ-018 decenas, unidades and pm SHALL be registered, computed from the next value of hora, so they show the new hour on the same edge that hora changes.
REQ-019 In 24 h mode, decenas:unidades SHALL show hora as 00-23 BCD.
REQ-020 In 12 h mode, hora 0 SHALL display as 12, hora 1-12 as 01-12, and hora 13-23 as hora-12 (01-11).
REQ-021 A change of modo12 SHALL take effect on the next clock edge without altering hora.
REQ-022 unidades SHALL never exceed 9, decenas SHALL never exceed 2, and no illegal BCD code SHALL appear on any cycle after the first post-reset edge.
REQ-023 With modifHor=0 and no ajPulse, all outputs SHALL hold their values and finDia SHALL be 0.

Reset
REQ-024 reset_n=0 SHALL immediately, without waiting for a clock, set hora=HORA_INICIAL, all synchronizer and edge flops to 0, finDia=0, pm=0, decenas=0 and unidades=0.
REQ-025 On the first clock edge after reset_n rises, the display SHALL update to HORA_INICIAL formatted for the current modo12.
REQ-026 A reset asserted mid-count or mid-press SHALL discard any pending ajPulse.
REQ-027 If ajusteHor is already held high when reset releases, it SHALL NOT generate a pulse until it is released and pressed again.

Verification
REQ-028 Reset, modo12=0, then 23 modifHor pulses SHALL give 23 with pm=1; the 24th pulse SHALL give 00 with pm=0 and finDia=1 for one cycle.
REQ-029 With modo12=1, a 24-pulse sweep SHALL display the sequence 12,01..11,12,01..11, with pm=0 for the first 12 values and pm=1 for the next 12.
REQ-030 Holding ajusteHor high for 10 clocks from hora=5 SHALL give hora=6 exactly 3 edges after the press, with no further change.
REQ-031 At hora=23, ajusteHor alone SHALL give 00 with finDia=0; modifHor coincident with ajPulse at hora=7 SHALL give 08, not 09.
REQ-032 Asserting reset_n=0 between clock edges at hora=15 SHALL drive the outputs to 0/0, pm=0 and finDia=0 before the next edge; after release, the first edge SHALL show 00 in 24 h mode or 12 in 12 h mode.
